// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: level-triggered 640-column ADC trace capture with {volts,tenths} conversion.
// Optional `TRACE_CAPTURE_SLOPE_EN adds trig_slope for falling-edge triggering.
module trace_capture_buffer #(
    parameter int DEPTH        = 640,
    parameter int DECIM        = 1,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [7:0] sample_code,
    input  logic [7:0] trig_level,
    input  logic       auto_en,
`ifdef TRACE_CAPTURE_SLOPE_EN
    input  logic       trig_slope,
`endif
    input  logic       frame_done,
    input  logic [9:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_ready,
    output logic       trig_flag
);
    localparam int TW = $clog2(AUTO_TIMEOUT);
    localparam logic [TW-1:0] TO_MAX = TW'(AUTO_TIMEOUT - 1);
    localparam logic [7:0] DEC_MAX = 8'(DECIM - 1);
    localparam logic [9:0] LAST = 10'(DEPTH - 1);

    typedef enum logic [1:0] {WAIT_TRIG, CAPTURE, READY} state_t;

    state_t        state, state_n;
    logic [9:0]    wr_ptr, wr_ptr_n, waddr;
    logic [7:0]    decim_cnt, prev_code, prev_n, conv;
    logic [TW-1:0] timeout_cnt, timeout_n;
    logic          prev_ok, prev_ok_n, trig_n, accept, hit, we;
    logic [15:0]   prod;
    logic [5:0]    t;
    logic [7:0]    mem [DEPTH];

    assign accept      = sample_valid && decim_cnt == DEC_MAX;
    assign prod        = {8'd0, sample_code} * 16'd51;
    assign t           = 6'(prod >> 8);
    assign conv        = {4'(t / 6'd10), 4'(t % 6'd10)};
    assign frame_ready = state == READY;

`ifdef TRACE_CAPTURE_SLOPE_EN
    assign hit = prev_ok && (trig_slope ? (prev_code > trig_level && sample_code <= trig_level)
                                        : (prev_code < trig_level && sample_code >= trig_level));
`else
    assign hit = prev_ok && prev_code < trig_level && sample_code >= trig_level;
`endif

    always_comb begin
        state_n   = state;
        wr_ptr_n  = wr_ptr;
        timeout_n = timeout_cnt;
        prev_n    = prev_code;
        prev_ok_n = prev_ok;
        trig_n    = trig_flag;
        we        = 1'b0;
        waddr     = wr_ptr;
        case (state)
            WAIT_TRIG: if (accept) begin
                prev_n    = sample_code;
                prev_ok_n = 1'b1;
                if (hit || (auto_en && timeout_cnt == TO_MAX)) begin
                    we        = 1'b1;
                    waddr     = 10'd0;
                    wr_ptr_n  = 10'd1;
                    trig_n    = hit;
                    timeout_n = '0;
                    state_n   = CAPTURE;
                end else if (timeout_cnt != TO_MAX) begin
                    timeout_n = timeout_cnt + 1'b1;
                end
            end
            CAPTURE: if (accept) begin
                we       = 1'b1;
                wr_ptr_n = wr_ptr == LAST ? 10'd0 : wr_ptr + 10'd1;
                state_n  = wr_ptr == LAST ? READY : CAPTURE;
            end
            READY: if (frame_done) begin
                state_n   = WAIT_TRIG;
                prev_ok_n = 1'b0;
                timeout_n = '0;
            end
            default: state_n = WAIT_TRIG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= WAIT_TRIG;
            wr_ptr      <= '0;
            decim_cnt   <= '0;
            timeout_cnt <= '0;
            prev_code   <= '0;
            prev_ok     <= 1'b0;
            trig_flag   <= 1'b0;
            rd_data     <= '0;
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_ptr_n;
            timeout_cnt <= timeout_n;
            prev_code   <= prev_n;
            prev_ok     <= prev_ok_n;
            trig_flag   <= trig_n;
            decim_cnt   <= sample_valid ? (decim_cnt == DEC_MAX ? 8'd0 : decim_cnt + 8'd1) : decim_cnt;
            rd_data     <= rd_addr < 10'(DEPTH) ? mem[rd_addr] : 8'd0;
        end
    end

    // Memory keeps its contents through reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (we && rst_n) mem[waddr] <= conv;
    end
endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb_trace_capture_buffer: table vectors, directed corner sequences and randomized run against a frame-level model.
module tb_trace_capture_buffer;
    localparam int DEPTH = 640;
    localparam int DEC0 = 1, AT0 = 16;
    localparam int DEC1 = 4, AT1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, sv, ae, fd, fr, tf;
    logic [7:0] sc, tl, rd;
    logic [9:0] ra;
    logic       rst_n1, sv1, ae1, fd1, fr1, tf1;
    logic [7:0] sc1, tl1, rd1;
    logic [9:0] ra1;

    trace_capture_buffer #(.DEPTH(DEPTH), .DECIM(DEC0), .AUTO_TIMEOUT(AT0)) u0 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sv), .sample_code(sc), .trig_level(tl),
        .auto_en(ae),
`ifdef TRACE_CAPTURE_SLOPE_EN
        .trig_slope(1'b0),
`endif
        .frame_done(fd), .rd_addr(ra), .rd_data(rd), .frame_ready(fr), .trig_flag(tf));

    trace_capture_buffer #(.DEPTH(DEPTH), .DECIM(DEC1), .AUTO_TIMEOUT(AT1)) u1 (
        .clk(clk), .rst_n(rst_n1), .sample_valid(sv1), .sample_code(sc1), .trig_level(tl1),
        .auto_en(ae1),
`ifdef TRACE_CAPTURE_SLOPE_EN
        .trig_slope(1'b0),
`endif
        .frame_done(fd1), .rd_addr(ra1), .rd_data(rd1), .frame_ready(fr1), .trig_flag(tf1));

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] to_disp(input int c);
        int v;
        v = (c * 51) / 256;
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    // Frame-level model of u0: mode 0 = armed, 1 = capturing, 2 = frozen
    int         m_mode = 0, m_vcnt = 0, m_n = 0, m_prev = 0, m_cnt = 0;
    bit         m_flag = 0;
    logic [7:0] m_mem [DEPTH];
    bit         m_known [DEPTH];

    task automatic mwrite(input int code);
        m_mem[m_cnt] = to_disp(code);
        m_known[m_cnt] = 1'b1;
        m_cnt++;
        if (m_cnt == DEPTH) m_mode = 2;
    endtask

    task automatic step0();
        logic [7:0] exp_rd;
        bit rd_known, acc, real_t, auto_t;
        if (!rst_n) begin
            m_mode = 0; m_vcnt = 0; m_n = 0; m_flag = 0;
            exp_rd = 8'd0; rd_known = 1'b1;
        end else begin
            rd_known = ra >= DEPTH || m_known[ra];
            exp_rd = ra >= DEPTH ? 8'd0 : m_mem[ra];
            acc = sv && (m_vcnt % DEC0 == DEC0 - 1);
            if (sv) m_vcnt++;
            if (m_mode == 0 && acc) begin
                real_t = m_n > 0 && m_prev < int'(tl) && sc >= tl;
                auto_t = ae && m_n >= AT0 - 1;
                m_n++;
                m_prev = int'(sc);
                if (real_t || auto_t) begin
                    m_flag = real_t; m_mode = 1; m_cnt = 0;
                    mwrite(int'(sc));
                end
            end else if (m_mode == 1 && acc) begin
                mwrite(int'(sc));
            end else if (m_mode == 2 && fd) begin
                m_mode = 0; m_n = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("frame_ready", fr, m_mode == 2);
        chk("trig_flag", tf, m_flag);
        if (rd_known) chk("rd_data", rd, exp_rd);
    endtask

    task automatic feed0(input int code);
        sv = 1'b1; sc = 8'(code); fd = 1'b0;
        step0();
    endtask

    task automatic rd0(input int addr, output logic [7:0] v);
        sv = 1'b0; fd = 1'b0; ra = 10'(addr);
        step0();
        v = rd;
    endtask

    task automatic pulse_done0();
        sv = 1'b0; fd = 1'b1;
        step0();
        fd = 1'b0;
    endtask

    task automatic step1();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int         code;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int nv;
        bit seen;
        int ks [6];
        tbl = '{'{0, 8'h00}, '{5, 8'h00}, '{6, 8'h01}, '{128, 8'h25}, '{255, 8'h50}, '{50, 8'h09},
                '{100, 8'h19}, '{200, 8'h39}, '{51, 8'h10}, '{26, 8'h05}, '{127, 8'h25}, '{250, 8'h49}};
        ks = '{0, 1, 2, 3, 100, 639};
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        rst_n = 1'b0; sv = 1'b0; sc = '0; tl = '0; ae = 1'b0; fd = 1'b0; ra = '0;
        rst_n1 = 1'b0; sv1 = 1'b0; sc1 = '0; tl1 = '0; ae1 = 1'b0; fd1 = 1'b0; ra1 = '0;
        step0();
        step0();
        chk("reset_ready", fr, 1'b0);
        chk("reset_flag", tf, 1'b0);
        chk("reset_rd", rd, 8'h00);

        // Conversion table: level 0 never crosses, so the 16th sample auto-starts at addr 0
        rst_n = 1'b1; tl = 8'd0; ae = 1'b1;
        for (int i = 0; i < AT0 - 1; i++) feed0(0);
        for (int i = 0; i < 12; i++) feed0(tbl[i].code);
        for (int k = 0; k < 700 && m_mode != 2; k++) feed0(0);
        chk("conv_ready", fr, 1'b1);
        chk("conv_flag", tf, 1'b0);
        for (int i = 0; i < 12; i++) begin
            rd0(i, v);
            chk("conv_col", v, tbl[i].exp);
        end
        rd0(640, v);
        chk("rd_640", v, 8'h00);
        rd0(1023, v);
        chk("rd_1023", v, 8'h00);
        pulse_done0();
        chk("done_clears_ready", fr, 1'b0);

        // Rising trigger on a ramp, with frame_done pulses during capture
        tl = 8'd128; ae = 1'b0;
        for (int i = 0; i < 768; i++) begin
            if (i == 767) chk("ramp_not_ready_early", fr, 1'b0);
            fd = (i == 300 || i == 500);
            sv = 1'b1; sc = 8'(i % 256);
            step0();
        end
        fd = 1'b0;
        chk("ramp_ready", fr, 1'b1);
        chk("ramp_flag", tf, 1'b1);
        rd0(0, v);
        chk("ramp_addr0", v, 8'h25);
        rd0(127, v);
        chk("ramp_addr127", v, 8'h50);

        // After re-arm the stale prev_code must not count as a crossing
        tl = 8'd250;
        pulse_done0();
        chk("rearm_ready", fr, 1'b0);
        feed0(255);
        feed0(0);
        feed0(255);
        for (int i = 0; i < 638; i++) feed0(0);
        chk("rearm_not_ready", fr, 1'b0);
        feed0(0);
        chk("rearm_ready_late", fr, 1'b1);

        // Reset while wr_ptr == 300
        tl = 8'd128;
        pulse_done0();
        for (int i = 0; i < 428; i++) feed0(i % 256);
        rst_n = 1'b0; ra = 10'd5; sv = 1'b1;
        step0();
        chk("midrst_ready", fr, 1'b0);
        chk("midrst_rd", rd, 8'h00);
        rst_n = 1'b1; tl = 8'd200;
        for (int i = 0; i < 840; i++) feed0(i % 256);
        chk("after_rst_ready", fr, 1'b1);
        rd0(0, v);
        chk("after_rst_addr0", v, 8'h39);
        rd0(55, v);
        chk("after_rst_addr55", v, 8'h50);

        // Auto trigger on a flat trace
        pulse_done0();
        tl = 8'd200; ae = 1'b1;
        for (int i = 0; i < 654; i++) feed0(50);
        chk("auto_not_ready", fr, 1'b0);
        feed0(50);
        chk("auto_ready", fr, 1'b1);
        chk("auto_flag", tf, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            rd0(i, v);
            chk("auto_col", v, 8'h09);
        end
        pulse_done0();
        ae = 1'b0;
        for (int i = 0; i < 2000; i++) feed0(50);
        chk("noauto_ready", fr, 1'b0);

        // Real trigger and timeout on the same sample
        rst_n = 1'b0;
        step0();
        rst_n = 1'b1; tl = 8'd128; ae = 1'b1;
        for (int i = 0; i < AT0 - 1; i++) feed0(0);
        feed0(200);
        for (int i = 0; i < 639; i++) feed0(0);
        chk("both_ready", fr, 1'b1);
        chk("both_flag", tf, 1'b1);
        rd0(0, v);
        chk("both_addr0", v, 8'h39);

        // Randomized run against the model
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (cyc % 1000 == 0) begin
                tl = 8'($urandom);
                ae = 1'($urandom);
            end
            rst_n = $urandom_range(0, 4999) != 0;
            sv = $urandom_range(0, 3) != 0;
            sc = $urandom_range(0, 1) != 0 ? 8'($urandom) : 8'(cyc * 3);
            fd = m_mode == 2 ? $urandom_range(0, 19) == 0 : $urandom_range(0, 49) == 0;
            ra = 10'($urandom_range(0, 1023));
            step0();
        end
        rst_n = 1'b1; fd = 1'b0; sv = 1'b0;

        // Decimation by 4 with auto timeout 2: valid #7 lands in addr 0, every 4th valid after
        step1();
        chk("u1_reset_ready", fr1, 1'b0);
        chk("u1_reset_rd", rd1, 8'h00);
        rst_n1 = 1'b1; tl1 = 8'd0; ae1 = 1'b1;
        nv = 0; seen = 1'b0;
        for (int cyc = 0; cyc < 10000 && nv < 2564; cyc++) begin
            sv1 = $urandom_range(0, 2) != 0;
            sc1 = 8'(nv * 7);
            fd1 = cyc % 97 == 0;
            step1();
            if (sv1) nv++;
            if (nv == 2563 && !seen) begin
                seen = 1'b1;
                chk("u1_not_ready", fr1, 1'b0);
            end
        end
        sv1 = 1'b0; fd1 = 1'b0;
        chk("u1_valid_count", nv, 2564);
        chk("u1_ready", fr1, 1'b1);
        chk("u1_flag", tf1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ra1 = 10'(ks[i]);
            step1();
            chk("u1_col", rd1, to_disp(((7 + 4 * ks[i]) * 7) % 256));
        end
        fd1 = 1'b1;
        step1();
        fd1 = 1'b0;
        chk("u1_done", fr1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
